// File: rtl/reg_file_16b8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_16b8: 16x16 register file, one synchronous write port and two   |
// | asynchronous read ports (A, B) with no write-to-read bypass.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reg_file_16b8 #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] WriteAddr,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic [ADDR_WIDTH-1:0] ReadAddrA,
  output logic [DATA_WIDTH-1:0] ReadDataA,
  input  logic [ADDR_WIDTH-1:0] ReadAddrB,
  output logic [DATA_WIDTH-1:0] ReadDataB
);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (Write) begin
      regs_d[WriteAddr] = DataIn;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the flops, so a same-address write is seen only after the edge.
  assign ReadDataA = regs_q[ReadAddrA];
  assign ReadDataB = regs_q[ReadAddrB];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_16b8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_file_16b8: directed and random checks of reg_file_16b8 against a  |
// | simple array model of the register contents.                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_reg_file_16b8;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [3:0]  waddr;
  logic [15:0] din;
  logic [3:0]  raddr_a;
  logic [15:0] rdata_a;
  logic [3:0]  raddr_b;
  logic [15:0] rdata_b;

  logic [15:0] model [16];
  int          n_cmp;
  int          n_bad;

  reg_file_16b8 #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4),
    .DEPTH     (16)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .Write    (wr),
    .WriteAddr(waddr),
    .DataIn   (din),
    .ReadAddrA(raddr_a),
    .ReadDataA(rdata_a),
    .ReadAddrB(raddr_b),
    .ReadDataB(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ports(input string tag);
    chk({tag, "_A"}, rdata_a, model[raddr_a]);
    chk({tag, "_B"}, rdata_b, model[raddr_b]);
  endtask

  // One rising edge; the model commits the write only when out of reset.
  task automatic edge_and_settle();
    @(posedge clk);
    if (rst_n && wr) model[waddr] = din;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    // Reset held while writes are attempted across several edges.
    rst_n   = 1'b0;
    wr      = 1'b1;
    din     = 16'h1234;
    waddr   = 4'd5;
    raddr_a = 4'd0;
    raddr_b = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      waddr = waddr + 4'd3;
    end
    #1;
    for (int a = 0; a < 16; a++) begin
      raddr_a = 4'(a);
      raddr_b = 4'(15 - a);
      #1;
      chk("reset_A", rdata_a, 16'h0000);
      chk("reset_B", rdata_b, 16'h0000);
    end

    @(negedge clk);
    wr    = 1'b0;
    rst_n = 1'b1;

    // Sequential fill of reg[0..8] with i+1.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      waddr   = 4'(i);
      din     = 16'(i + 1);
      wr      = 1'b1;
      raddr_a = 4'(i);
      raddr_b = 4'(i + 1);
      edge_and_settle();
      chk("fill_A", rdata_a, 16'(i + 1));
      chk("fill_B", rdata_b, 16'h0000);
    end

    // Write disabled: reg[3] keeps its value.
    @(negedge clk);
    wr      = 1'b0;
    waddr   = 4'd3;
    din     = 16'hFFFF;
    raddr_a = 4'd3;
    edge_and_settle();
    chk("wr_disable", rdata_a, 16'h0004);

    // Read during write, same address: old value before edge, new after.
    @(negedge clk);
    wr      = 1'b1;
    waddr   = 4'd15;
    din     = 16'hBEEF;
    raddr_a = 4'd15;
    #1;
    chk("rdw_before", rdata_a, 16'h0000);
    edge_and_settle();
    chk("rdw_after", rdata_a, 16'hBEEF);

    // Dual-port independence.
    @(negedge clk);
    wr      = 1'b0;
    raddr_a = 4'd2;
    raddr_b = 4'd2;
    #1;
    chk("dual_same_A", rdata_a, 16'h0003);
    chk("dual_same_B", rdata_b, 16'h0003);
    raddr_b = 4'd7;
    #1;
    chk("dual_B7", rdata_b, 16'h0008);
    chk("dual_A_hold", rdata_a, 16'h0003);

    // Random traffic against the model, checking reads before and after each edge.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      wr      = ($urandom_range(0, 3) != 0);
      waddr   = 4'($urandom_range(0, 15));
      din     = 16'($urandom);
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
      raddr_b = 4'($urandom_range(0, 15));
      #1;
      chk_ports("rand_pre");
      edge_and_settle();
      chk_ports("rand_post");
    end

    // Asynchronous reset between edges.
    @(negedge clk);
    wr = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    #1;
    rst_n   = 1'b0;
    raddr_a = 4'd2;
    raddr_b = 4'd15;
    #1;
    chk("async_rst_A", rdata_a, 16'h0000);
    chk("async_rst_B", rdata_b, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr      = 1'b1;
    waddr   = 4'd0;
    din     = 16'hA5A5;
    raddr_a = 4'd0;
    raddr_b = 4'd1;
    edge_and_settle();
    chk("post_rst_wr0", rdata_a, 16'hA5A5);
    chk("post_rst_r1", rdata_b, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_16b8.md
Name: reg_file_16b8

Overview:
- Multi-port general-purpose register file for the accumulator processor datapath.
- 16 entries × 16 bits; one synchronous write port and two independent asynchronous (combinational) read ports, A and B.
- Sits between the control unit (addresses, write enable) and the ALU/accumulator (read data).

Parameters:
DATA_WIDTH, 16, width of each register and of the data ports
ADDR_WIDTH, 4, width of every address port
DEPTH, 16, number of registers (2**ADDR_WIDTH); every address value selects a real register

Ports:
CLK  input  1  system clock; writes commit on rising edge
RST_N  input  1  asynchronous active-low reset; clears all registers
Write  input  1  write enable, active high, sampled on rising CLK
WriteAddr  input  4  index of the register written
DataIn  input  16  write data
ReadAddrA  input  4  read port A index
ReadDataA  output  16  contents of register[ReadAddrA]
ReadAddrB  input  4  read port B index
ReadDataB  output  16  contents of register[ReadAddrB]

Behaviour:
- Storage: 16 registers, reg[0]..reg[15], 16 bits each. Register 0 is an ordinary writable register, not hardwired to zero.
- Reset:
  - RST_N low forces all 16 registers to 0x0000 immediately, independent of CLK.
  - Both read outputs therefore show 0x0000 while reset is held.
  - Reset overrides any write in progress; a write edge that occurs while RST_N is low is discarded.
  - Registers stay at zero until the first write after RST_N rises.
- Write:
  - On a CLK rising edge with RST_N high and Write=1, reg[WriteAddr] <= DataIn.
  - With Write=0, no register changes.
  - Only the addressed register is modified.
  - WriteAddr and DataIn are sampled only at the edge.
- Read:
  - Purely combinational. ReadDataA = reg[ReadAddrA] and ReadDataB = reg[ReadAddrB].
  - Outputs update within the same cycle as an address change; there is no read latency.
- Read during write to the same address:
  - No internal bypass.
  - Before the rising edge, the port shows the old value.
  - After the edge, it shows the new value (write-then-read latency of one edge).
- Both ports may address the same register simultaneously and return identical data.
- Any address combination is legal; there are no out-of-range cases.
- Values wrap modulo 2^16. The block performs no arithmetic.
- No X propagation after reset: every output is defined once RST_N has been asserted.

Test Plan:
- Reset: hold RST_N=0, Write=1, DataIn=0x1234, toggle CLK -> ReadDataA/B read 0x0000 for every address 0..15.
- Sequential fill:
  - For i=0..8, set WriteAddr=i, DataIn=i+1, Write=1, ReadAddrA=i, ReadAddrB=i+1, then pulse CLK.
  - After each edge, ReadDataA=i+1. ReadDataB=0x0000 (not yet written).
  - After the loop, reg[0..8] = 1..9.
- Write disable: Write=0, WriteAddr=3, DataIn=0xFFFF, clock edge -> reg[3] still reads 0x0004.
- Read-during-write on the same address:
  - Set ReadAddrA=WriteAddr=15 and DataIn=0xBEEF; before the edge, ReadDataA=0x0000.
  - After the edge, ReadDataA=0xBEEF.
- Dual-port independence: ReadAddrA=ReadAddrB=2 -> both outputs read 0x0003; change only ReadAddrB to 7 -> ReadDataB=0x0008 combinationally, ReadDataA unchanged.
- Async reset mid-operation: with registers populated, drop RST_N between clock edges -> outputs go to 0x0000 without a CLK edge; release RST_N and write 0xA5A5 to addr 0 -> reads back 0xA5A5.
